// File: rtl/wb_host_initiator.sv
// wb_host_initiator: Wishbone classic single-transfer initiator with no-ack timeout
// and saturating timeout statistics.
module wb_host_initiator #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_CNT_WIDTH   = 8
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [31:0]             cmd_adr,
   input  logic [31:0]             cmd_dat,
   input  logic [3:0]              cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [31:0]             rsp_dat,
   output logic                    rsp_err,
   output logic                    wbm_cyc_o,
   output logic                    wbm_stb_o,
   output logic                    wbm_we_o,
   output logic [3:0]              wbm_sel_o,
   output logic [31:0]             wbm_adr_o,
   output logic [31:0]             wbm_dat_o,
   input  logic [31:0]             wbm_dat_i,
   input  logic                    wbm_ack_i,
   output logic                    busy,
   output logic [TO_CNT_WIDTH-1:0] stat_timeouts
);
   localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2;
   localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   logic [1:0]              state_q, state_d;
   logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d, stat_q, stat_d;
   logic                    cyc_q, cyc_d, we_q, we_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [3:0]              sel_q, sel_d;
   logic [31:0]             adr_q, adr_d, dat_q, dat_d, rsp_dat_q, rsp_dat_d;
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stat_d      = stat_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d = BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = cmd_we;
            sel_d   = cmd_sel;
            adr_d   = cmd_adr;
            dat_d   = cmd_we ? cmd_dat : 32'h0;
         end
         BUS: begin
            // ack has priority over a timeout expiring on the same edge
            if (wbm_ack_i || cnt_q == TO_LAST) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_dat_d   = wbm_ack_i ? wbm_dat_i : 32'h0;
               rsp_err_d   = !wbm_ack_i;
               stat_d      = (!wbm_ack_i && stat_q != '1) ? stat_q + 1'b1 : stat_q;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         RESP: if (rsp_ready) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stat_q      <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stat_q      <= stat_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
      end
   end
   assign cmd_ready     = state_q == IDLE;
   assign busy          = state_q != IDLE;
   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_we_o      = we_q;
   assign wbm_sel_o     = sel_q;
   assign wbm_adr_o     = adr_q;
   assign wbm_dat_o     = dat_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_dat       = rsp_dat_q;
   assign rsp_err       = rsp_err_q;
   assign stat_timeouts = stat_q;
endmodule

// File: tb/tb_wb_host_initiator.sv
// tb_wb_host_initiator: randomized bench with a register-file slave model and
// transaction-level expectations for the Wishbone initiator.
module tb_wb_host_initiator;
   localparam int TO = 16;
   logic        wb_clk_i = 1'b0, wb_rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0, wbm_ack_i = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0, wbm_dat_i = '0;
   logic [3:0]  cmd_sel = '0;
   logic        cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy;
   logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [7:0]  stat_timeouts;
   int          n_tests = 0, n_fail = 0;
   logic [7:0]  stat_exp = '0;
   logic [31:0] mem [logic [31:0]];

   wb_host_initiator #(.TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(8)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
      .busy(busy), .stat_timeouts(stat_timeouts));

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave register pairs: a write to an 8-byte-aligned slot is readable at either word.
   function automatic logic [31:0] slave_rd(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:3], 3'b000};
      if (a == 32'h3000_0004) return 32'h4669_626F;
      if (mem.exists(k)) return mem[k];
      return k ^ 32'hA5A5_A5A5;
   endfunction

   task automatic slave_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] k, v;
      k = {a[31:3], 3'b000};
      v = mem.exists(k) ? mem[k] : 32'h0;
      for (int b = 0; b < 4; b++)
         if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
      mem[k] = v;
   endtask

   // lat = stb-high cycle in which the slave acks (0 = never)
   task automatic run(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                      input int lat, input int hold, input bit trail);
      logic        exp_err;
      logic [31:0] exp_dat;
      int          hi, at;
      bit          got;
      exp_err = lat < 1 || lat > TO;
      exp_dat = exp_err ? 32'h0 : (we ? 32'h1 : slave_rd(a));
      @(negedge wb_clk_i);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = a; cmd_dat = d; cmd_sel = sel;
      check("cmd_ready_idle", cmd_ready, 1);
      hi = 0; at = -1; got = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge wb_clk_i);
         if (c == 0) begin
            cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_we = $urandom;
            check("cyc_after_accept", wbm_cyc_o, 1);
            check("stb_after_accept", wbm_stb_o, 1);
            check("we_o", wbm_we_o, we);
            check("adr_o", wbm_adr_o, a);
            check("sel_o", wbm_sel_o, sel);
            check("dat_o", wbm_dat_o, we ? d : 32'h0);
            check("busy_bus", busy, 1);
            check("cmd_ready_bus", cmd_ready, 0);
         end
         if (rsp_valid) begin
            got = 1; at = c;
            break;
         end
         if (wbm_stb_o) hi++;
         wbm_ack_i = wbm_stb_o && hi == lat;
         wbm_dat_i = wbm_ack_i ? (we ? 32'h1 : slave_rd(a)) : $urandom;
      end
      wbm_ack_i = trail;
      wbm_dat_i = $urandom;
      check("rsp_seen", got, 1);
      check("stb_high_cycles", hi, exp_err ? TO : lat);
      check("latency", at, exp_err ? TO : lat);
      check("cyc_dropped", wbm_cyc_o, 0);
      check("rsp_dat", rsp_dat, exp_dat);
      check("rsp_err", rsp_err, exp_err);
      if (exp_err) stat_exp = (stat_exp == 8'hFF) ? 8'hFF : stat_exp + 8'd1;
      else if (we) slave_wr(a, d, sel);
      check("stat_timeouts", stat_timeouts, stat_exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge wb_clk_i);
         check("hold_valid", rsp_valid, 1);
         check("hold_dat", rsp_dat, exp_dat);
         check("hold_err", rsp_err, exp_err);
         check("hold_cmd_ready", cmd_ready, 0);
         wbm_ack_i = $urandom; wbm_dat_i = $urandom; cmd_valid = $urandom;
      end
      rsp_ready = 1'b1; cmd_valid = 1'b1;
      @(negedge wb_clk_i);
      rsp_ready = 1'b0; cmd_valid = 1'b0; wbm_ack_i = 1'b0;
      check("rsp_released", rsp_valid, 0);
      check("cmd_ready_after", cmd_ready, 1);
      check("not_accepted_in_resp", busy, 0);
      check("cyc_idle", wbm_cyc_o, 0);
   endtask

   initial begin
      repeat (3) @(negedge wb_clk_i);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cyc", wbm_cyc_o, 0);
      check("rst_stb", wbm_stb_o, 0);
      check("rst_busy", busy, 0);
      check("rst_adr", wbm_adr_o, 0);
      check("rst_rsp_dat", rsp_dat, 0);
      check("rst_stat", stat_timeouts, 0);
      wb_rst_n = 1'b1;
      run(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 0, 0);
      run(1'b1, 32'h3000_0018, 32'hCAFE_BABE, 4'hF, 2, 0, 0);
      run(1'b0, 32'h3000_001C, 32'h0, 4'hF, 3, 0, 0);
      run(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0, 0);
      run(1'b0, 32'h3000_0004, 32'h0, 4'hF, 4, 0, 0);
      run(1'b0, 32'h3000_0004, 32'h0, 4'hF, TO, 0, 0);
      run(1'b1, 32'h3000_0028, 32'h1234_5678, 4'h5, TO + 1, 0, 0);
      run(1'b0, 32'h3000_0004, 32'h0, 4'hF, 5, 10, 1);
      for (int i = 0; i < 40; i++)
         run(1'($urandom), 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom,
             4'($urandom), $urandom_range(0, 20), $urandom_range(0, 4), 1'($urandom));
      @(negedge wb_clk_i);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0004; cmd_sel = 4'hF;
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      check("pre_rst_busy", busy, 1);
      wb_rst_n = 1'b0;
      @(negedge wb_clk_i);
      wb_rst_n = 1'b1;
      stat_exp = '0;
      check("midrst_cyc", wbm_cyc_o, 0);
      check("midrst_stb", wbm_stb_o, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_stat", stat_timeouts, 0);
      repeat (3) begin
         @(negedge wb_clk_i);
         check("post_rst_no_rsp", rsp_valid, 0);
         check("post_rst_ready", cmd_ready, 1);
      end
      for (int i = 0; i < 3; i++)
         run(1'b0, 32'h3000_0004 + 32'(8 * i), 32'h0, 4'hF, $urandom_range(1, TO), 0, 0);
      for (int i = 0; i < 258; i++)
         run(1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 0, 0);
      check("stat_saturated", stat_timeouts, 8'hFF);
      run(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
